// File: rtl/demux1to4_stream_if.sv
// Stream bundle for the 1-to-4 demux: one valid/ready input and four
// valid/ready output channels. Each output channel also has a transfer counter.
interface demux1to4_stream_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [1:0]            in_sel;
  logic                  in_mode;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [4*DATA_W-1:0]   out_data;
  logic [4*CNT_W-1:0]    out_count;

  // The demux block itself sits on the slave side.
  modport slave (
    input  in_valid, in_data, in_sel, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  // The producer and consumers together sit on the master side.
  modport master (
    output in_valid, in_data, in_sel, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/demux1to4_stream.sv
// 1-to-4 stream demultiplexer. Each input word goes to one of four
// one-entry output registers. The target channel comes from in_sel or from a
// round-robin pointer. Every channel counts its completed output transfers.

// One output channel: a one-entry register plus a transfer counter.
module demux1to4_stream_chan #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] q,
  output logic [CNT_W-1:0]  count
);
  logic xfer;

  assign xfer = valid && ready;

  // A load wins over a drain. This lets a full channel take a new word in the
  // same cycle it hands one off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

  // Completed output transfers. The counter wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (xfer) count <= count + 1'b1;
  end
endmodule

module demux1to4_stream #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst,
  demux1to4_stream_if.slave bus
);
  localparam int NUM_CH = 4;

  logic [1:0]                     rr_ptr;
  logic [1:0]                     target;
  logic                           accept;
  logic [NUM_CH-1:0]              valid;
  logic [NUM_CH-1:0][DATA_W-1:0]  q;
  logic [NUM_CH-1:0][CNT_W-1:0]   count;

  // Pick the channel for the current input word.
  always_comb begin
    target = bus.in_mode ? rr_ptr : bus.in_sel;
  end

  // Ready depends only on the target channel's state, never on in_valid.
  // A stalled channel blocks the input only while it is the target.
  assign bus.in_ready = !rst && (!valid[target] || bus.out_ready[target]);
  assign accept       = bus.in_valid && bus.in_ready;

  // The round-robin pointer moves only on round-robin accepts. A switch to
  // steered mode leaves it where it is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rr_ptr <= '0;
    else if (accept && bus.in_mode)  rr_ptr <= rr_ptr + 2'd1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux1to4_stream_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .load  (accept && (target == 2'(k))),
      .data  (bus.in_data),
      .ready (bus.out_ready[k]),
      .valid (valid[k]),
      .q     (q[k]),
      .count (count[k])
    );
  end

  // The packed layout puts channel k at [k*W +: W] of the flat buses.
  assign bus.out_valid = valid;
  assign bus.out_data  = q;
  assign bus.out_count = count;
endmodule
